// File: rtl/host_csr_regs.sv
// Control/status register slave for the vjtag_host bus: LEDs, synchronized switches,
// scratch register, prescaled down-counting timer with interrupt, and sticky W1C status.
module host_csr_regs #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter logic [15:0] ID_VALUE = 16'hC5A1,
  parameter int unsigned PRESCALE = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soft_rst_n,
  input  logic [AW-1:0] address,
  input  logic          wvalid,
  input  logic [DW-1:0] wdata,
  output logic          wready,
  input  logic          rvalid,
  output logic          rready,
  output logic          rrvalid,
  output logic [DW-1:0] rdata,
  input  logic [15:0]   sw_in,
  output logic [15:0]   led_out,
  output logic          irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

  localparam logic [2:0] IdxId      = 3'd0;
  localparam logic [2:0] IdxLed     = 3'd1;
  localparam logic [2:0] IdxSw      = 3'd2;
  localparam logic [2:0] IdxScratch = 3'd3;
  localparam logic [2:0] IdxTctrl   = 3'd4;
  localparam logic [2:0] IdxTload   = 3'd5;
  localparam logic [2:0] IdxTcount  = 3'd6;
  localparam logic [2:0] IdxStatus  = 3'd7;

  logic [15:0]   sw_meta_q, sw_sync_q, sw_prev_q;
  logic          wready_q;
  logic [15:0]   led_q, led_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [2:0]    tctrl_q, tctrl_d;
  logic [DW-1:0] tload_q, tload_d;
  logic [DW-1:0] tcount_q, tcount_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    status_q, status_d;
  logic          rrvalid_q, rrvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic          mapped, rd_acc, tick, en_rise;
  logic          wr_led, wr_scratch, wr_tctrl, wr_tload, wr_status;
  logic [2:0]    idx, set_bits;
  logic [DW-1:0] rd_val;
  logic          unused_addr;

  assign unused_addr = ^address[1:0];
  assign idx         = address[4:2];
  assign mapped      = (address[AW-1:5] == '0);
  assign rd_acc      = rvalid && rready;

  assign wr_led     = wvalid && mapped && (idx == IdxLed);
  assign wr_scratch = wvalid && mapped && (idx == IdxScratch);
  assign wr_tctrl   = wvalid && mapped && (idx == IdxTctrl);
  assign wr_tload   = wvalid && mapped && (idx == IdxTload);
  assign wr_status  = wvalid && mapped && (idx == IdxStatus);

  assign tick    = tctrl_q[0] && (pre_q == PreMax);
  assign en_rise = wr_tctrl && wdata[0] && !tctrl_q[0];

  // Read mux always sees pre-write register values.
  always_comb begin
    rd_val = '0;
    case (idx)
      IdxId:      rd_val = DW'(ID_VALUE);
      IdxLed:     rd_val = DW'(led_q);
      IdxSw:      rd_val = DW'(sw_sync_q);
      IdxScratch: rd_val = scratch_q;
      IdxTctrl:   rd_val = DW'(tctrl_q);
      IdxTload:   rd_val = tload_q;
      IdxTcount:  rd_val = tcount_q;
      IdxStatus:  rd_val = DW'(status_q);
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    led_d     = wr_led ? wdata[15:0] : led_q;
    scratch_d = wr_scratch ? wdata : scratch_q;
    tctrl_d   = tctrl_q;
    tload_d   = tload_q;
    tcount_d  = tcount_q;
    set_bits  = '0;

    if (!tctrl_q[0] || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    if (tick) begin
      if (tcount_q != '0) begin
        tcount_d = tcount_q - DW'(1);
      end else begin
        set_bits[0] = 1'b1;
        if (tctrl_q[1]) begin
          tcount_d = tload_q;
        end else begin
          tctrl_d[0] = 1'b0;
        end
      end
    end

    // Software writes override the hardware EN clear and any timer count update.
    if (wr_tctrl) begin
      tctrl_d = wdata[2:0];
      if (en_rise) tcount_d = tload_q;
    end
    if (wr_tload) begin
      tload_d  = wdata;
      tcount_d = wdata;
    end

    set_bits[1] = (sw_sync_q != sw_prev_q);
    set_bits[2] = (wvalid || rd_acc) && !mapped;

    status_d = wr_status ? (status_q & ~wdata[2:0]) : status_q;
    status_d = status_d | set_bits;

    rrvalid_d = rd_acc;
    rdata_d   = rd_acc ? (mapped ? rd_val : '0) : rdata_q;
    irq_d     = tctrl_q[2] && status_q[0];
  end

  // Synchronizer chain is untouched by the soft reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_prev_q <= '0;
      wready_q  <= 1'b0;
    end else begin
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
      wready_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !soft_rst_n) begin
      led_q     <= rst_n ? 16'h0000 : 16'hFFFF;
      scratch_q <= '0;
      tctrl_q   <= '0;
      tload_q   <= '0;
      tcount_q  <= '0;
      pre_q     <= '0;
      status_q  <= '0;
      rrvalid_q <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      scratch_q <= scratch_d;
      tctrl_q   <= tctrl_d;
      tload_q   <= tload_d;
      tcount_q  <= tcount_d;
      pre_q     <= pre_d;
      status_q  <= status_d;
      rrvalid_q <= rrvalid_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign wready  = wready_q;
  assign rready  = !rrvalid_q;
  assign rrvalid = rrvalid_q;
  assign rdata   = rdata_q;
  assign led_out = led_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_host_csr_regs.sv
// Directed plus randomized bench for host_csr_regs with a reference register model.
module tb_host_csr_regs;
  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_rst_n = 1'b1;
  logic [15:0] address = '0;
  logic        wvalid = 1'b0;
  logic [15:0] wdata = '0;
  logic        wready;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        rrvalid;
  logic [15:0] rdata;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  host_csr_regs #(
    .AW(16),
    .DW(16),
    .ID_VALUE(16'hC5A1),
    .PRESCALE(P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .soft_rst_n(soft_rst_n),
    .address(address),
    .wvalid(wvalid),
    .wdata(wdata),
    .wready(wready),
    .rvalid(rvalid),
    .rready(rready),
    .rrvalid(rrvalid),
    .rdata(rdata),
    .sw_in(sw_in),
    .led_out(led_out),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a;
    wdata   = d;
    wvalid  = 1'b1;
    step();
    wvalid  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    check("rready_idle", rready, 1);
    address = a;
    rvalid  = 1'b1;
    step();
    rvalid  = 1'b0;
    check("rrvalid_pulse", rrvalid, 1);
    check("rready_busy", rready, 0);
    d = rdata;
    step();
    check("rrvalid_drop", rrvalid, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  logic [15:0] model [8];
  logic [15:0] d;
  int unsigned t0, t1, exp_cyc, pulses, idx;

  initial begin
    // Hard reset
    repeat (3) step();
    check("rst_wready", wready, 0);
    check("rst_led", led_out, 16'hFFFF);
    check("rst_irq", irq, 0);
    check("rst_rrvalid", rrvalid, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_wready", wready, 1);
    check("post_rst_rready", rready, 1);
    check("post_rst_rdata", rdata, 16'h0000);
    rd_chk("id", 16'h0000, 16'hC5A1);
    rd_chk("led_reset", 16'h0004, 16'hFFFF);

    // Soft reset, also dropping a read accepted in the same cycle
    wr(16'h000C, 16'h5A5A);
    wr(16'h0004, 16'hA5A5);
    check("led_write", led_out, 16'hA5A5);
    address    = 16'h000C;
    rvalid     = 1'b1;
    soft_rst_n = 1'b0;
    step();
    rvalid     = 1'b0;
    soft_rst_n = 1'b1;
    check("soft_led", led_out, 16'h0000);
    check("soft_rrvalid", rrvalid, 0);
    check("soft_wready", wready, 1);
    rd_chk("soft_scratch", 16'h000C, 16'h0000);

    // Back-to-back reads
    wr(16'h000C, 16'h1234);
    address = 16'h000C;
    rvalid  = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) check($sformatf("b2b_rready%0d", i), rready, (i % 2 == 0) ? 1 : 0);
      if (i == 4) rvalid = 1'b0;
      step();
      if (rrvalid) begin
        pulses++;
        check("b2b_data", rdata, 16'h1234);
      end
    end
    check("b2b_pulses", pulses, 2);

    // Auto-reload timer with interrupt, TLOAD=3
    wr(16'h0014, 16'd3);
    wr(16'h0010, 16'h0007);
    t0 = cyc;
    exp_cyc = t0 + (3 + 1) * P + 1;
    while (irq !== 1'b1 && cyc < t0 + 200) step();
    check("irq_rise1", cyc, exp_cyc);
    wr(16'h001C, 16'h0001);
    check("irq_hold", irq, 1);
    step();
    check("irq_clear", irq, 0);
    exp_cyc = t0 + 2 * (3 + 1) * P + 1;
    while (irq !== 1'b1 && cyc < t0 + 200) step();
    check("irq_rise2", cyc, exp_cyc);
    wr(16'h0010, 16'h0000);
    step();
    check("irq_off", irq, 0);
    wr(16'h001C, 16'h0007);

    // One-shot timer, TLOAD=2
    wr(16'h0014, 16'd2);
    wr(16'h0010, 16'h0001);
    t1 = cyc;
    rd_chk("oneshot_tctrl_run", 16'h0010, 16'h0001);
    rd_chk("oneshot_tcount_run", 16'h0018, 16'h0002);
    while (cyc < t1 + 20) step();
    rd_chk("oneshot_tctrl_done", 16'h0010, 16'h0000);
    rd_chk("oneshot_tcount_done", 16'h0018, 16'h0000);
    rd_chk("oneshot_status", 16'h001C, 16'h0001);
    check("oneshot_irq", irq, 0);
    wr(16'h001C, 16'h0007);

    // Switch synchronizer and change flag
    sw_in = 16'h00F0;
    rd_chk("sw_early", 16'h0008, 16'h0000);
    rd_chk("sw_late", 16'h0008, 16'h00F0);
    rd_chk("sw_changed", 16'h001C, 16'h0002);

    // Unmapped accesses
    rd_chk("unmapped_read", 16'h0040, 16'h0000);
    wr(16'h0040, 16'hFFFF);
    check("unmapped_write_led", led_out, 16'h0000);
    rd_chk("bus_err", 16'h001C, 16'h0006);

    // Randomized accesses against the register model (timer disabled)
    model[0] = 16'hC5A1;
    model[1] = 16'h0000;
    model[2] = 16'h00F0;
    model[3] = 16'h1234;
    model[4] = 16'h0000;
    model[5] = 16'h0002;
    model[6] = 16'h0000;
    model[7] = 16'h0000;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(6);
      if ($urandom_range(1) == 1) begin
        if (idx == 4) idx = 3;
        d = 16'($urandom);
        wr(16'(idx * 4), d);
        if (idx == 1 || idx == 3 || idx == 5) model[idx] = d;
        if (idx == 5) model[6] = d;
      end else begin
        rd_chk($sformatf("rand_rd_%0d", idx), 16'(idx * 4), model[idx]);
      end
      check("rand_led", led_out, model[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
